// File: rtl/layer_output_collector_pkg.sv
// Shared constants for the layer output collector and the neuron channel split.
// Lane 0 of a packed multi-channel word always occupies the most significant slice.
package layer_output_collector_pkg;

    // Width of a packed index, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of a lane inside a packed word (lane 0 sits at the top)
    function automatic int lane_lsb(input int lane, input int channels, input int width);
        return (channels - 1 - lane) * width;
    endfunction

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int NUM_NEURONS_DEF  = 32;
    localparam int OUT_CHANNELS_DEF = 4;
    localparam int WORDS_DEF        = NUM_NEURONS_DEF / OUT_CHANNELS_DEF;
    localparam int WORD_IDX_W_DEF   = idx_width(WORDS_DEF);

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/layer_output_collector_bank.sv
// One half of the ping-pong buffer: slot storage, capture mask, full flag
// and a read mux that packs one output word selected by word index.
module collector_bank
    import layer_output_collector_pkg::*;
#(
    parameter int NUM_NEURONS  = NUM_NEURONS_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int OUT_CHANNELS = OUT_CHANNELS_DEF,
    parameter int WORD_IDX_W   = WORD_IDX_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_sel,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0]  neuron_out,
    input  logic [NUM_NEURONS-1:0]             neuron_valid,
    input  logic                               release_bank,
    input  logic [WORD_IDX_W-1:0]              word_idx,
    output logic                               full,
    output logic                               partial,
    output logic                               complete,
    output logic                               drop,
    output logic [OUT_CHANNELS*DATA_WIDTH-1:0] rd_word
);

    localparam int SLOT_W = idx_width(NUM_NEURONS);

    logic [NUM_NEURONS-1:0]                 mask;
    logic [NUM_NEURONS-1:0]                 accept;
    logic [NUM_NEURONS-1:0]                 mask_next;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] slots;

    // Only the write bank captures, and only into slots not yet filled
    assign accept    = (wr_sel && !full) ? (neuron_valid & ~mask) : '0;
    assign mask_next = mask | accept;
    assign complete  = wr_sel && !full && (&mask_next);
    // A repeat pulse, or any pulse while this write bank is still full, is lost
    assign drop      = wr_sel && (|(neuron_valid & (mask | {NUM_NEURONS{full}})));
    assign partial   = |mask;

    // Mask accumulates captures; completion turns the mask into the full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= '0;
            full <= 1'b0;
        end else if (complete) begin
            mask <= '0;
            full <= 1'b1;
        end else begin
            mask <= mask_next;
            if (release_bank)
                full <= 1'b0;
        end
    end

    // Per-slot storage, written once per vector so held data is never overwritten
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_slot
        always_ff @(posedge clk) begin
            if (accept[n])
                slots[n] <= neuron_out[n*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Lane c of the selected word comes from slot word_idx*OUT_CHANNELS+c
    for (genvar c = 0; c < OUT_CHANNELS; c++) begin : g_lane
        logic [SLOT_W-1:0] lane_sel;
        assign lane_sel = SLOT_W'(int'(word_idx) * OUT_CHANNELS + c);
        assign rd_word[lane_lsb(c, OUT_CHANNELS, DATA_WIDTH) +: DATA_WIDTH] = slots[lane_sel];
    end

endmodule

// File: rtl/layer_output_collector.sv
// Collects skewed neuron outputs into a ping-pong buffer and replays each
// completed layer vector as packed multi-channel words with back-pressure.
module layer_output_collector
    import layer_output_collector_pkg::*;
#(
    parameter int NUM_NEURONS  = NUM_NEURONS_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int OUT_CHANNELS = OUT_CHANNELS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0]  neuron_out,
    input  logic [NUM_NEURONS-1:0]             neuron_valid,
    output logic [OUT_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy,
    output logic                               overflow
);

    localparam int WORDS      = NUM_NEURONS / OUT_CHANNELS;
    localparam int WORD_IDX_W = idx_width(WORDS);

    rd_state_e                                  state;
    logic                                       wr_ptr;
    logic                                       rd_ptr;
    logic [WORD_IDX_W-1:0]                      word_idx;
    logic [1:0]                                 full;
    logic [1:0]                                 partial;
    logic [1:0]                                 complete;
    logic [1:0]                                 drop;
    logic [1:0][OUT_CHANNELS*DATA_WIDTH-1:0]    rd_word;
    logic                                       last_word;
    logic                                       last_accept;

    assign last_word   = (word_idx == WORD_IDX_W'(WORDS - 1));
    assign last_accept = (state == RD_STREAM) && out_valid && out_ready && last_word;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        collector_bank #(
            .NUM_NEURONS  (NUM_NEURONS),
            .DATA_WIDTH   (DATA_WIDTH),
            .OUT_CHANNELS (OUT_CHANNELS),
            .WORD_IDX_W   (WORD_IDX_W)
        ) u_bank (
            .clk          (clk),
            .rst          (rst),
            .wr_sel       (wr_ptr == 1'(b)),
            .neuron_out   (neuron_out),
            .neuron_valid (neuron_valid),
            .release_bank (last_accept && (rd_ptr == 1'(b))),
            .word_idx     (word_idx),
            .full         (full[b]),
            .partial      (partial[b]),
            .complete     (complete[b]),
            .drop         (drop[b]),
            .rd_word      (rd_word[b])
        );
    end

    // Stored data is static while a bank is full, so the mux output holds under stall
    assign out_data = rd_word[rd_ptr];
    assign busy     = (|full) || (|partial);

    // Write pointer moves to the other bank as soon as the current one completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wr_ptr <= 1'b0;
        else if (|complete)
            wr_ptr <= ~wr_ptr;
    end

    // Sticky drop indicator, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overflow <= 1'b0;
        else if (|drop)
            overflow <= 1'b1;
    end

    // Read FSM: stream the read bank word by word, chaining straight into the other bank if ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RD_IDLE;
            rd_ptr    <= 1'b0;
            word_idx  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (full[rd_ptr]) begin
                        state     <= RD_STREAM;
                        word_idx  <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (WORDS == 1);
                    end
                end
                RD_STREAM: begin
                    if (out_ready) begin
                        if (last_word) begin
                            rd_ptr   <= ~rd_ptr;
                            word_idx <= '0;
                            if (full[~rd_ptr]) begin
                                out_last <= (WORDS == 1);
                            end else begin
                                state     <= RD_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            out_last <= ((word_idx + 1'b1) == WORD_IDX_W'(WORDS - 1));
                        end
                    end
                end
                default: begin
                    state     <= RD_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_collector.sv
// Scoreboard bench: a vector-level model predicts words, drops and busy; a
// negedge monitor compares everything the DUT presents against it.
module tb_layer_output_collector;

    localparam int NN    = 8;
    localparam int DW    = 16;
    localparam int OC    = 4;
    localparam int WORDS = NN / OC;
    localparam int OW    = OC * DW;

    typedef struct {
        logic [OW-1:0] d;
        logic          last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [NN*DW-1:0] neuron_out;
    logic [NN-1:0]    neuron_valid;
    logic [OW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             overflow;

    layer_output_collector #(
        .NUM_NEURONS  (NN),
        .DATA_WIDTH   (DW),
        .OUT_CHANNELS (OC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state (written only by the monitor)
    exp_t            exp_q[$];
    logic [NN-1:0]   m_seen;
    logic [DW-1:0]   m_vals[NN];
    int              m_pending;
    bit              m_ovf;
    int              lat_stage;
    bit              bubble_chk;
    bit              final_done;
    int              n_pass;
    int              n_tot;

    // Stimulus-owned flags read by the monitor
    int              drain_timeouts;
    bit              final_chk;

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    initial begin
        m_seen = '0; m_pending = 0; m_ovf = 0; lat_stage = 0; bubble_chk = 0;
        final_done = 0; n_pass = 0; n_tot = 0;
    end

    // Monitor and reference model: compares at negedge, then predicts the next posedge
    always @(negedge clk) begin : monitor
        bit   freed;
        int   pend_pre;
        exp_t e;
        logic [OW-1:0] w;
        freed = 0;
        if (!rst) begin
            chk("rst_out_valid", OW'(out_valid), '0);
            chk("rst_busy", OW'(busy), '0);
            chk("rst_overflow", OW'(overflow), '0);
            exp_q.delete();
            m_seen = '0; m_pending = 0; m_ovf = 0; lat_stage = 0; bubble_chk = 0;
        end else begin
            if (lat_stage == 2) begin
                chk("lat_early", OW'(out_valid), '0);
                lat_stage = 1;
            end else if (lat_stage == 1) begin
                chk("lat_valid", OW'(out_valid), OW'(1));
                lat_stage = 0;
            end
            if (bubble_chk) begin
                chk("no_bubble", OW'(out_valid), OW'(1));
                bubble_chk = 0;
            end
            chk("busy", OW'(busy), OW'((m_pending > 0) || (|m_seen)));
            chk("overflow", OW'(overflow), OW'(m_ovf));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", OW'(out_valid), '0);
                end else begin
                    e = exp_q[0];
                    chk("out_data", out_data, e.d);
                    chk("out_last", OW'(out_last), OW'(e.last));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (e.last) freed = 1;
                    end
                end
            end
            // Captures see the occupancy before this edge's release
            pend_pre = m_pending;
            for (int n = 0; n < NN; n++) begin
                if (neuron_valid[n]) begin
                    if (pend_pre == 2 || m_seen[n]) m_ovf = 1;
                    else begin
                        m_vals[n] = neuron_out[n*DW +: DW];
                        m_seen[n] = 1'b1;
                    end
                end
            end
            if (freed) m_pending--;
            if (&m_seen) begin
                for (int wi = 0; wi < WORDS; wi++) begin
                    w = '0;
                    for (int c = 0; c < OC; c++) w = (w << DW) | OW'(m_vals[wi*OC + c]);
                    e.d = w;
                    e.last = (wi == WORDS - 1);
                    exp_q.push_back(e);
                end
                if (m_pending == 0) lat_stage = 2;
                m_pending++;
                m_seen = '0;
            end
            if (freed && pend_pre == 2) bubble_chk = 1;
        end
        if (final_chk && !final_done) begin
            chk("drain_timeouts", OW'(drain_timeouts), '0);
            chk("queue_empty", OW'(exp_q.size()), '0);
            final_done = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [NN-1:0] m);
        neuron_valid = m;
        tick();
        neuron_valid = '0;
    endtask

    task automatic rand_vals();
        for (int n = 0; n < NN; n++) neuron_out[n*DW +: DW] = DW'($urandom);
    endtask

    task automatic wait_drain(input int bound);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_pending != 0) && k < bound) begin
            tick();
            k++;
        end
        if (k >= bound) drain_timeouts++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        neuron_valid = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [NN-1:0] rem;
        logic [NN-1:0] m;
        drain_timeouts = 0;
        final_chk = 0;
        rst = 1'b0;
        out_ready = 1'b0;
        neuron_valid = '0;
        neuron_out = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // All neurons on one cycle, values n+1
        out_ready = 1'b1;
        for (int n = 0; n < NN; n++) neuron_out[n*DW +: DW] = DW'(n + 1);
        fire('1);
        wait_drain(50);

        // Neuron n fires at cycle 3n
        rand_vals();
        for (int n = 0; n < NN; n++) begin
            fire(NN'(1) << n);
            tick();
            tick();
        end
        wait_drain(50);

        // Stall 10 cycles on the second word
        out_ready = 1'b0;
        rand_vals();
        fire('1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (10) tick();
        out_ready = 1'b1;
        wait_drain(50);

        // Random skew and random back-pressure
        for (int v = 0; v < 20; v++) begin
            rand_vals();
            rem = '1;
            while (rem != '0) begin
                m = rem & NN'($urandom);
                rem = rem & ~m;
                neuron_valid = m;
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            neuron_valid = '0;
        end
        out_ready = 1'b1;
        wait_drain(200);

        // Two banks filled under back-pressure, third vector dropped
        do_reset();
        out_ready = 1'b0;
        rand_vals();
        fire('1);
        tick();
        rand_vals();
        fire('1);
        tick();
        rand_vals();
        fire('1);
        repeat (3) tick();
        out_ready = 1'b1;
        wait_drain(50);

        // Duplicate pulse on neuron 3 keeps the first value
        do_reset();
        out_ready = 1'b1;
        rand_vals();
        fire(NN'(1) << 3);
        neuron_out[3*DW +: DW] = DW'($urandom);
        fire(NN'(1) << 3);
        fire(~(NN'(1) << 3));
        wait_drain(50);

        // Reset during the second word of a stream, then a fresh vector
        do_reset();
        out_ready = 1'b1;
        rand_vals();
        fire('1);
        tick();
        tick();
        #1 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rand_vals();
        fire('1);
        wait_drain(50);

        final_chk = 1;
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
